grid_cursor_ctrl: RTL and testbench
===================================

Name: grid_cursor_ctrl

Overview:
- Parametrised cursor and turn controller for the board-game datapath.
- Takes debounced button levels and moves a row/column cursor over a ROWS x COLS board.
- Issues single-cycle write strobes carrying the current player id, and rotates turns among NPLAYERS.
- Adds wrap/saturate mode, hold-to-repeat, occupied-cell rejection and a defined new-game handoff. Sits between the debouncers and the board memory / win checker.

Parameters:
- ROWS, 3, board rows (>=2).
- COLS, 3, board columns (>=2).
- NPLAYERS, 2, player count (2..7).
- WRAP, 1, 1 = cursor wraps at both edges on both axes; 0 = cursor saturates at edges.
- REPEAT_DLY, 0, cycles a direction button is held before the first auto-repeat step; 0 disables repeat.
- REPEAT_PER, 1, cycles between subsequent auto-repeat steps (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_c  in  1  debounced centre button level (place / new game)
- btn_l  in  1  debounced left level
- btn_r  in  1  debounced right level
- btn_u  in  1  debounced up level
- btn_d  in  1  debounced down level
- cell_occupied  in  1  board content at addr is non-empty (combinational read of board memory)
- game_over  in  1  win checker: game finished, held until new_game
- draw  in  1  valid with game_over: board full, no winner
- winner  in  PW  valid with game_over and !draw: winning player id; PW = clog2(NPLAYERS+1)
- row  out  RW  cursor row; RW = clog2(ROWS)
- col  out  CW  cursor column; CW = clog2(COLS)
- addr  out  RW+CW  {row,col} board address
- wd  out  PW  current player id, 1..NPLAYERS; 0 is reserved for empty
- wen  out  1  one-cycle write strobe
- new_game  out  1  one-cycle pulse; board memory and win checker clear on it

Behaviour:
- Reset (async, rst_n=0):
  - row=0, col=0, wd=1, starter=1, wen=0, new_game=0.
  - Edge-detect and repeat state cleared; all buttons treated as previously low.
- Press event:
  - Button sampled 1 at edge k after 0 at edge k-1.
  - Cursor updates at edge k. wen/new_game are registered and high in the cycle after edge k.
- Auto-repeat (REPEAT_DLY>0, direction buttons only):
  - While held, extra step events fire REPEAT_DLY cycles after the press, then every REPEAT_PER cycles.
  - Release clears the counter. btn_c never repeats.
- Axis conflict: l+r step events in the same cycle cancel (no move); same for u+d. Row and column axes move independently in the same cycle.
- Column stepping:
  - r: col+1. At COLS-1 → 0 if WRAP, else hold.
  - l: col-1. At 0 → COLS-1 if WRAP, else hold.
- Row stepping:
  - d: row+1. At ROWS-1 → 0 if WRAP, else hold.
  - u: row-1. At 0 → ROWS-1 if WRAP, else hold.
- row and col never leave 0..ROWS-1 / 0..COLS-1.
- Centre event with game_over=0:
  - cell_occupied=1 (sampled at edge k): no wen, wd unchanged.
  - Otherwise: wen=1 in cycle k+1 with addr/wd equal to the pre-advance values.
  - wd advances at edge k+1: next(p) = p+1, or 1 after NPLAYERS.
- Centre event with game_over=1:
  - No wen; new_game=1 in cycle k+1.
  - starter <= draw ? next(starter) : next(winner); wd <= the same value at edge k+1. Cursor unchanged.
- Centre plus direction events in the same cycle: the move applies at edge k, so wen uses the new addr in cycle k+1.
- Cursor movement is permitted while game_over=1.
- wen and new_game are never high together, and each is never high two consecutive cycles from a single press.
- Reset mid-hold: after release of reset, a still-held button counts as a new press at its first sampled-high edge.

Decomposition:
- Shared package grid_pkg:
  - clog2 function.
  - PLAYER_NONE=0.
  - next_player(p, n) function.
  - Default ROWS/COLS/NPLAYERS constants.
- Sub-module btn_repeat (clk, rst_n, level, step; parameters DLY, PER):
  - Contains the edge detector plus repeat counter.
  - Instantiated for l/r/u/d, and for c with DLY=0.

Test Plan:
- Defaults, WRAP=1: press r three times from reset → col 1, 2, 0; then press u once → row=2, addr={2,0}.
- WRAP=0: press l at col=0 and u at row=0 → row/col stay 0. Press l and r in the same cycle at col=1 → col stays 1.
- REPEAT_DLY=8, REPEAT_PER=4, COLS=5: hold r for 20 cycles → steps at press, +8, +12, +16, +20 cycles; col=0 → 4, then wraps to 0.
- Centre on an empty cell: wen=1 for exactly one cycle with wd=1, addr=cursor; then wd=2. Centre on the same cell with cell_occupied=1 → no wen, wd stays 2.
- NPLAYERS=3, game_over=1, winner=3, draw=0: centre → new_game pulse, wd=1, no wen. Repeat with draw=1 and starter=1 → wd=2.
- Assert rst_n=0 while holding d mid-repeat → all outputs at reset values. Release with d held → one step at the first edge, repeat restarts from DLY.

Source files
------------

// File: rtl/grid_pkg.sv
// ---------------------------------------------------------------------------
// grid_pkg
// Shared definitions for the board-game cursor/turn controller.
//   clog2        : ceiling log2, never less than 1 (usable for port widths)
//   next_player  : turn rotation 1..n, wrapping back to 1
//   PLAYER_NONE  : board value meaning "empty cell"
//   dir_e        : index of each direction button in the step vector
//   DEF_*        : default board geometry and player count
// ---------------------------------------------------------------------------
package grid_pkg;

  localparam int DEF_ROWS     = 3;
  localparam int DEF_COLS     = 3;
  localparam int DEF_NPLAYERS = 2;

  localparam int PLAYER_NONE  = 0;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  // Ceiling log2 with a floor of 1 so a 1-state range still gets a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Player after p among 1..n. Anything out of range restarts at player 1,
  // so the empty id can never be handed out as a turn.
  function automatic int next_player(input int p, input int n);
    return (p >= n || p <= PLAYER_NONE) ? 1 : p + 1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// ---------------------------------------------------------------------------
// btn_repeat
// Rising-edge detector with optional hold-to-repeat for one debounced button.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (button treated as low before)
//   level  in  debounced button level
//   step   out combinational step event, consumed at the coming clk edge
// Parameters:
//   DLY  edges after the press edge before the first repeat (0 = no repeat)
//   PER  edges between later repeats (>=1)
// ---------------------------------------------------------------------------
module btn_repeat
  import grid_pkg::*;
#(
  parameter int DLY = 0,
  parameter int PER = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic step
);

  logic r_prev;
  logic w_press;

  assign w_press = level & ~r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= level;
  end

  generate
    if (DLY > 0) begin : g_rep
      localparam int CMAX = (DLY > PER) ? DLY : PER;
      localparam int CNTW = clog2(CMAX + 1);

      // Down-counter: edges remaining until the next repeat fires. Loaded
      // on the press edge so a fire lands exactly DLY edges later, then
      // reloaded with PER-1 on each fire.
      logic [CNTW-1:0] r_cnt;
      logic            w_fire;

      assign w_fire = level & r_prev & (r_cnt == '0);
      assign step   = w_press | w_fire;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_cnt <= '0;
        else if (!level)  r_cnt <= '0;
        else if (w_press) r_cnt <= CNTW'(DLY - 1);
        else if (w_fire)  r_cnt <= CNTW'(PER - 1);
        else              r_cnt <= r_cnt - CNTW'(1);
      end
    end else begin : g_norep
      assign step = w_press;
    end
  endgenerate

endmodule

// File: rtl/grid_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// grid_cursor_ctrl
// Cursor and turn controller between the button debouncers and the board
// memory / win checker.
//   clk, rst_n            clock, asynchronous active-low reset
//   btn_c/l/r/u/d         debounced button levels
//   cell_occupied         board content at addr is non-empty
//   game_over/draw/winner win checker status (held until new_game)
//   row, col, addr        cursor position, addr = {row,col}
//   wd                    current player id (1..NPLAYERS)
//   wen                   one-cycle write strobe for the board memory
//   new_game              one-cycle clear pulse for board and win checker
// ---------------------------------------------------------------------------
module grid_cursor_ctrl
  import grid_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int NPLAYERS   = DEF_NPLAYERS,
  parameter int WRAP       = 1,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 1,
  localparam int RW = clog2(ROWS),
  localparam int CW = clog2(COLS),
  localparam int PW = clog2(NPLAYERS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_c,
  input  logic            btn_l,
  input  logic            btn_r,
  input  logic            btn_u,
  input  logic            btn_d,
  input  logic            cell_occupied,
  input  logic            game_over,
  input  logic            draw,
  input  logic [PW-1:0]   winner,
  output logic [RW-1:0]   row,
  output logic [CW-1:0]   col,
  output logic [RW+CW-1:0] addr,
  output logic [PW-1:0]   wd,
  output logic            wen,
  output logic            new_game
);

  logic [3:0]    w_lvl;
  logic [3:0]    w_step;
  logic          w_step_c;
  logic [RW-1:0] w_row_next;
  logic [CW-1:0] w_col_next;
  logic          w_place;
  logic          w_new;
  logic [PW-1:0] w_start_next;

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [PW-1:0] r_wd;
  logic [PW-1:0] r_starter;
  logic          r_wen;
  logic          r_new_game;

  assign w_lvl = {btn_d, btn_u, btn_r, btn_l};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      btn_repeat #(
        .DLY (REPEAT_DLY),
        .PER (REPEAT_PER)
      ) u_rep (
        .clk   (clk),
        .rst_n (rst_n),
        .level (w_lvl[gi]),
        .step  (w_step[gi])
      );
    end
  endgenerate

  btn_repeat #(
    .DLY (0),
    .PER (1)
  ) u_rep_c (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_c),
    .step  (w_step_c)
  );

  // Column axis: opposing steps in the same cycle cancel.
  always_comb begin
    w_col_next = r_col;
    if (w_step[DIR_R] && !w_step[DIR_L]) begin
      if (r_col == CW'(COLS - 1)) w_col_next = (WRAP != 0) ? '0 : r_col;
      else                        w_col_next = r_col + CW'(1);
    end else if (w_step[DIR_L] && !w_step[DIR_R]) begin
      if (r_col == '0) w_col_next = (WRAP != 0) ? CW'(COLS - 1) : r_col;
      else             w_col_next = r_col - CW'(1);
    end
  end

  // Row axis, independent of the column axis.
  always_comb begin
    w_row_next = r_row;
    if (w_step[DIR_D] && !w_step[DIR_U]) begin
      if (r_row == RW'(ROWS - 1)) w_row_next = (WRAP != 0) ? '0 : r_row;
      else                        w_row_next = r_row + RW'(1);
    end else if (w_step[DIR_U] && !w_step[DIR_D]) begin
      if (r_row == '0) w_row_next = (WRAP != 0) ? RW'(ROWS - 1) : r_row;
      else             w_row_next = r_row - RW'(1);
    end
  end

  assign w_place = w_step_c & ~game_over & ~cell_occupied;
  assign w_new   = w_step_c & game_over;

  // Next game's starter: after a draw the opening rotates, otherwise the
  // player after the winner opens.
  assign w_start_next = draw ? PW'(next_player(int'(r_starter), NPLAYERS))
                             : PW'(next_player(int'(winner), NPLAYERS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_wd       <= PW'(1);
      r_starter  <= PW'(1);
      r_wen      <= 1'b0;
      r_new_game <= 1'b0;
    end else begin
      r_row      <= w_row_next;
      r_col      <= w_col_next;
      r_wen      <= w_place;
      r_new_game <= w_new;
      // Starter is latched with the status seen at the press edge; wd
      // follows one edge later so the strobe cycle still shows the old id.
      if (w_new) r_starter <= w_start_next;
      if (r_new_game)  r_wd <= r_starter;
      else if (r_wen)  r_wd <= PW'(next_player(int'(r_wd), NPLAYERS));
    end
  end

  assign row      = r_row;
  assign col      = r_col;
  assign addr     = {r_row, r_col};
  assign wd       = r_wd;
  assign wen      = r_wen;
  assign new_game = r_new_game;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grid_cursor_ctrl
// DUT A: 3x5 board, 3 players, wrapping, repeat after 8 then every 4 edges.
//        Every edge a reference model pushes the expected outputs to a
//        scoreboard queue; they are popped and compared 1 time unit later.
// DUT B: 3x3 board, 2 players, saturating, no repeat; directed checks.
// ---------------------------------------------------------------------------
module tb_grid_cursor_ctrl;

  localparam int A_ROWS = 3;
  localparam int A_COLS = 5;
  localparam int A_NP   = 3;
  localparam int A_DLY  = 8;
  localparam int A_PER  = 4;

  localparam logic [4:0] BTN_C = 5'b00001;
  localparam logic [4:0] BTN_L = 5'b00010;
  localparam logic [4:0] BTN_R = 5'b00100;
  localparam logic [4:0] BTN_U = 5'b01000;
  localparam logic [4:0] BTN_D = 5'b10000;

  logic       clk;
  logic       rst_n;

  logic [4:0] a_btn;
  logic       a_occ, a_go, a_draw;
  logic [1:0] a_winner;
  logic [1:0] a_row;
  logic [2:0] a_col;
  logic [4:0] a_addr;
  logic [1:0] a_wd;
  logic       a_wen, a_ng;

  logic [4:0] b_btn;
  logic       b_occ, b_go, b_draw;
  logic [1:0] b_winner;
  logic [1:0] b_row;
  logic [1:0] b_col;
  logic [3:0] b_addr;
  logic [1:0] b_wd;
  logic       b_wen, b_ng;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  typedef struct {
    int row;
    int col;
    int wd;
    bit wen;
    bit ng;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state for DUT A
  int     m_row, m_col, m_wd, m_starter;
  bit     m_wen, m_ng;
  bit [4:0] m_prev;
  int     m_hold[5];

  grid_cursor_ctrl #(
    .ROWS(A_ROWS), .COLS(A_COLS), .NPLAYERS(A_NP), .WRAP(1),
    .REPEAT_DLY(A_DLY), .REPEAT_PER(A_PER)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .btn_c(a_btn[0]), .btn_l(a_btn[1]), .btn_r(a_btn[2]),
    .btn_u(a_btn[3]), .btn_d(a_btn[4]),
    .cell_occupied(a_occ), .game_over(a_go), .draw(a_draw), .winner(a_winner),
    .row(a_row), .col(a_col), .addr(a_addr), .wd(a_wd),
    .wen(a_wen), .new_game(a_ng)
  );

  grid_cursor_ctrl #(
    .ROWS(3), .COLS(3), .NPLAYERS(2), .WRAP(0),
    .REPEAT_DLY(0), .REPEAT_PER(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .btn_c(b_btn[0]), .btn_l(b_btn[1]), .btn_r(b_btn[2]),
    .btn_u(b_btn[3]), .btn_d(b_btn[4]),
    .cell_occupied(b_occ), .game_over(b_go), .draw(b_draw), .winner(b_winner),
    .row(b_row), .col(b_col), .addr(b_addr), .wd(b_wd),
    .wen(b_wen), .new_game(b_ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(input int p, input int n);
    return (p >= n) ? 1 : p + 1;
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_wd = 1; m_starter = 1;
    m_wen = 0; m_ng = 0; m_prev = '0;
    for (int i = 0; i < 5; i++) m_hold[i] = 0;
  endtask

  // Behaviour of DUT A at one rising edge, expressed from the press/hold
  // point of view: m_hold = edges elapsed since the press edge.
  task automatic model_edge();
    bit   ev[5];
    exp_t e;
    ev[0] = a_btn[0] && !m_prev[0];
    for (int i = 1; i < 5; i++) begin
      if (a_btn[i] && !m_prev[i]) begin
        ev[i] = 1'b1;
        m_hold[i] = 0;
      end else if (a_btn[i]) begin
        m_hold[i]++;
        ev[i] = (m_hold[i] == A_DLY) ||
                (m_hold[i] > A_DLY && ((m_hold[i] - A_DLY) % A_PER) == 0);
      end else begin
        ev[i] = 1'b0;
        m_hold[i] = 0;
      end
    end
    m_prev = a_btn;
    if (m_ng)       m_wd = m_starter;
    else if (m_wen) m_wd = nxt(m_wd, A_NP);
    if (ev[2] && !ev[1])      m_col = (m_col == A_COLS - 1) ? 0 : m_col + 1;
    else if (ev[1] && !ev[2]) m_col = (m_col == 0) ? A_COLS - 1 : m_col - 1;
    if (ev[4] && !ev[3])      m_row = (m_row == A_ROWS - 1) ? 0 : m_row + 1;
    else if (ev[3] && !ev[4]) m_row = (m_row == 0) ? A_ROWS - 1 : m_row - 1;
    m_wen = ev[0] && !a_go && !a_occ;
    m_ng  = ev[0] && a_go;
    if (m_ng) m_starter = a_draw ? nxt(m_starter, A_NP) : nxt(int'(a_winner), A_NP);
    e.row = m_row; e.col = m_col; e.wd = m_wd; e.wen = m_wen; e.ng = m_ng;
    sb_q.push_back(e);
  endtask

  // One clock transaction: model pushes, DUT sampled 1 unit after the edge.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("a_row", a_row, e.row);
      chk("a_col", a_col, e.col);
      chk("a_addr", a_addr, e.row * 8 + e.col);
      chk("a_wd", a_wd, e.wd);
      chk("a_wen", a_wen, e.wen);
      chk("a_ng", a_ng, e.ng);
    end
    n_txn++;
    $display("txn %0d A btn=%b row=%0d col=%0d wd=%0d wen=%0b ng=%0b | B btn=%b row=%0d col=%0d wd=%0d wen=%0b ng=%0b",
             n_txn, a_btn, a_row, a_col, a_wd, a_wen, a_ng,
             b_btn, b_row, b_col, b_wd, b_wen, b_ng);
  endtask

  task automatic press(input logic [4:0] am, input logic [4:0] bm);
    a_btn = am; b_btn = bm;
    cyc();
    a_btn = '0; b_btn = '0;
    cyc();
  endtask

  task automatic chk_reset_vals(input string where);
    chk({where, "_a_row"}, a_row, 0);
    chk({where, "_a_col"}, a_col, 0);
    chk({where, "_a_wd"},  a_wd, 1);
    chk({where, "_a_wen"}, a_wen, 0);
    chk({where, "_a_ng"},  a_ng, 0);
    chk({where, "_b_row"}, b_row, 0);
    chk({where, "_b_col"}, b_col, 0);
    chk({where, "_b_wd"},  b_wd, 1);
    chk({where, "_b_wen"}, b_wen, 0);
    chk({where, "_b_ng"},  b_ng, 0);
  endtask

  initial begin
    int exp_col[3];
    exp_col = '{1, 2, 3};
    a_btn = '0; a_occ = 0; a_go = 0; a_draw = 0; a_winner = '0;
    b_btn = '0; b_occ = 0; b_go = 0; b_draw = 0; b_winner = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    // A: right steps with wrap, left wraps past 0, up wraps to last row
    for (int i = 0; i < 3; i++) begin
      press(BTN_R, '0);
      chk("a_r_seq", a_col, exp_col[i]);
    end
    repeat (4) press(BTN_L, '0);
    chk("a_l_wrap", a_col, 4);
    press(BTN_U, '0);
    chk("a_u_wrap", a_row, 2);
    chk("a_addr_24", a_addr, 5'b10100);

    // A: same-axis conflicts cancel, other axis still moves
    press(BTN_L | BTN_R, '0);
    chk("a_lr_cancel", a_col, 4);
    press(BTN_U | BTN_D | BTN_R, '0);
    chk("a_ud_cancel", a_row, 2);
    chk("a_r_indep", a_col, 0);

    // A: hold right for 21 edges: steps at +0, +8, +12, +16, +20
    a_btn = BTN_R;
    for (int i = 0; i <= 20; i++) begin
      cyc();
      if (i == 0)  chk("a_rep_press", a_col, 1);
      if (i == 7)  chk("a_rep_pre8", a_col, 1);
      if (i == 8)  chk("a_rep_8", a_col, 2);
      if (i == 12) chk("a_rep_12", a_col, 3);
      if (i == 16) chk("a_rep_16", a_col, 4);
      if (i == 20) chk("a_rep_20", a_col, 0);
    end
    a_btn = '0;
    cyc();

    // A: placement on an empty cell, then on an occupied one
    a_btn = BTN_C;
    cyc();
    chk("a_place_wen", a_wen, 1);
    chk("a_place_wd", a_wd, 1);
    chk("a_place_addr", a_addr, 5'b10000);
    a_btn = '0;
    cyc();
    chk("a_place_wen_off", a_wen, 0);
    chk("a_place_wd_adv", a_wd, 2);
    a_occ = 1;
    a_btn = BTN_C;
    cyc();
    chk("a_occ_nowen", a_wen, 0);
    a_btn = '0;
    cyc();
    chk("a_occ_wd", a_wd, 2);
    a_occ = 0;

    // A: centre plus left in one cycle writes at the moved address
    a_btn = BTN_C | BTN_L;
    cyc();
    chk("a_cmove_wen", a_wen, 1);
    chk("a_cmove_addr", a_addr, 5'b10100);
    chk("a_cmove_wd", a_wd, 2);
    a_btn = '0;
    cyc();
    chk("a_cmove_wd_adv", a_wd, 3);

    // A: new-game handoff (winner, then two draws), movement while over
    a_go = 1; a_winner = 2'd3; a_draw = 0;
    a_btn = BTN_C;
    cyc();
    chk("a_ng_pulse", a_ng, 1);
    chk("a_ng_nowen", a_wen, 0);
    a_btn = '0;
    cyc();
    chk("a_ng_off", a_ng, 0);
    chk("a_ng_win_wd", a_wd, 1);
    a_draw = 1;
    press(BTN_C, '0);
    chk("a_ng_draw1_wd", a_wd, 2);
    press(BTN_C, '0);
    chk("a_ng_draw2_wd", a_wd, 3);
    press(BTN_R, '0);
    chk("a_go_move", a_col, 0);
    a_go = 0; a_draw = 0;

    // A: reset while d is held mid-repeat, release with d still held
    a_btn = BTN_D;
    repeat (10) cyc();
    chk("a_hold_d", a_row, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("a_rst_press", a_row, 1);
    repeat (7) cyc();
    chk("a_rst_pre8", a_row, 1);
    cyc();
    chk("a_rst_rep8", a_row, 2);
    a_btn = '0;
    cyc();

    // B: saturating edges, conflicts, no repeat
    press('0, BTN_L);
    chk("b_l_sat", b_col, 0);
    press('0, BTN_U);
    chk("b_u_sat", b_row, 0);
    press('0, BTN_R);
    chk("b_r1", b_col, 1);
    press('0, BTN_L | BTN_R);
    chk("b_lr_cancel", b_col, 1);
    press('0, BTN_R);
    press('0, BTN_R);
    chk("b_r_sat", b_col, 2);
    repeat (3) press('0, BTN_D);
    chk("b_d_sat", b_row, 2);
    b_btn = BTN_L;
    repeat (12) cyc();
    b_btn = '0;
    cyc();
    chk("b_norepeat", b_col, 1);

    // B: two-player rotation and new-game starter
    b_btn = BTN_C;
    cyc();
    chk("b_wen", b_wen, 1);
    chk("b_wen_wd", b_wd, 1);
    chk("b_wen_addr", b_addr, 4'b1001);
    b_btn = '0;
    cyc();
    chk("b_wen_off", b_wen, 0);
    chk("b_wd2", b_wd, 2);
    press('0, BTN_C);
    chk("b_wd_wrap", b_wd, 1);
    b_go = 1; b_winner = 2'd1; b_draw = 0;
    b_btn = BTN_C;
    cyc();
    chk("b_ng", b_ng, 1);
    chk("b_ng_nowen", b_wen, 0);
    b_btn = '0;
    cyc();
    chk("b_ng_wd", b_wd, 2);
    b_go = 0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
